// File: rtl/cpu_defs_pkg.sv
// Shared write-back definitions: target encodings, bus width helper and stage states.
package cpu_defs_pkg;

    localparam logic [2:0] AIM_GPR  = 3'd0;
    localparam logic [2:0] AIM_LO   = 3'd1;
    localparam logic [2:0] AIM_HI   = 3'd2;
    localparam logic [2:0] AIM_CP0  = 3'd3;
    localparam logic [2:0] AIM_HILO = 3'd4;

    // {en, aim[2:0], rd, sel, data_hi, data_lo}
    function automatic int unsigned wb_bus_w(input int unsigned dw, input int unsigned rw,
                                             input int unsigned sw);
        return 4 + rw + sw + 2 * dw;
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HI2   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_decode.sv
// Write-target decoder: aim -> one-hot write enables, gated by the beat's en bit.
module wb_decode
    import cpu_defs_pkg::*;
(
    input  logic       en,
    input  logic [2:0] aim,
    output logic       reg_en_c,
    output logic       lo_en_c,
    output logic       hi_en_c,
    output logic       cp0_en_c,
    output logic       illegal_c
);

    always_comb begin
        reg_en_c  = 1'b0;
        lo_en_c   = 1'b0;
        hi_en_c   = 1'b0;
        cp0_en_c  = 1'b0;
        illegal_c = 1'b0;
        if (en) begin
            case (aim)
                AIM_GPR:  reg_en_c = 1'b1;
                AIM_LO:   lo_en_c  = 1'b1;
                AIM_HI:   hi_en_c  = 1'b1;
                AIM_CP0:  cp0_en_c = 1'b1;
                AIM_HILO: begin
                    lo_en_c = 1'b1;
                    hi_en_c = 1'b1;
                end
                default:  illegal_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage_hs.sv
// One-entry registered write-back stage: holds a MEM beat and drives GPR/LO/HI/CP0 write ports.
module wb_stage_hs
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned RW         = 5,
    parameter int unsigned SW         = 3,
    parameter int unsigned SPLIT_HILO = 0,
    parameter int unsigned CW         = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [wb_bus_w(DW, RW, SW)-1:0]   in_bus,
    input  logic                              flush,
    output logic                              reg_en,
    output logic                              lo_en,
    output logic                              hi_en,
    output logic                              cp0_en,
    output logic [RW-1:0]                     rd,
    output logic [SW-1:0]                     sel,
    output logic [DW-1:0]                     w_data,
    output logic [DW-1:0]                     w_data_hi,
    output logic                              byp_valid,
    output logic [CW-1:0]                     retire_cnt,
    output logic                              err_illegal
);

    localparam int unsigned BW = wb_bus_w(DW, RW, SW);

    wb_state_t     state_q, state_d;
    logic [BW-1:0] bus_q, bus_d;
    logic          split_q, split_d;
    logic          in_ready_q, in_ready_d;
    logic          reg_en_q, reg_en_d, lo_en_q, lo_en_d, hi_en_q, hi_en_d, cp0_en_q, cp0_en_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] w_data_q, w_data_d, w_data_hi_q, w_data_hi_d;
    logic          byp_valid_q, byp_valid_d;
    logic [CW-1:0] retire_cnt_q, retire_cnt_d;
    logic          err_q, err_d;

    logic          accept_c, retire_c;
    logic          dec_reg_c, dec_lo_c, dec_hi_c, dec_cp0_c, dec_illegal_c, dec_any_c;

    assign accept_c = in_valid & in_ready_q & ~flush;

    // Write ports for the cycle after this edge are decoded from the beat held next.
    wb_decode u_decode (
        .en        (bus_d[BW-1]),
        .aim       (bus_d[BW-2 -: 3]),
        .reg_en_c  (dec_reg_c),
        .lo_en_c   (dec_lo_c),
        .hi_en_c   (dec_hi_c),
        .cp0_en_c  (dec_cp0_c),
        .illegal_c (dec_illegal_c)
    );

    assign dec_any_c = dec_reg_c | dec_lo_c | dec_hi_c | dec_cp0_c;

    always_comb begin
        state_d      = state_q;
        bus_d        = bus_q;
        split_d      = 1'b0;
        retire_c     = 1'b0;
        reg_en_d     = 1'b0;
        lo_en_d      = 1'b0;
        hi_en_d      = 1'b0;
        cp0_en_d     = 1'b0;
        rd_d         = '0;
        sel_d        = '0;
        w_data_d     = '0;
        w_data_hi_d  = '0;
        retire_cnt_d = retire_cnt_q;
        err_d        = err_q;

        if (accept_c) begin
            bus_d = in_bus;
        end

        case (state_q)
            EMPTY: state_d = accept_c ? FULL : EMPTY;
            FULL: begin
                if (split_q) begin
                    state_d = HI2;
                end else begin
                    retire_c = 1'b1;
                    state_d  = accept_c ? FULL : EMPTY;
                end
            end
            HI2: begin
                retire_c = 1'b1;
                state_d  = accept_c ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (retire_c) begin
            retire_cnt_d = retire_cnt_q + CW'(1);
        end

        // Next-cycle write ports; rd/sel/data stay zero whenever nothing is written.
        case (state_d)
            FULL: begin
                if ((SPLIT_HILO != 0) && dec_lo_c && dec_hi_c) begin
                    split_d  = 1'b1;
                    lo_en_d  = 1'b1;
                    rd_d     = bus_d[2*DW+SW +: RW];
                    sel_d    = bus_d[2*DW +: SW];
                    w_data_d = bus_d[0 +: DW];
                end else begin
                    reg_en_d = dec_reg_c;
                    lo_en_d  = dec_lo_c;
                    hi_en_d  = dec_hi_c;
                    cp0_en_d = dec_cp0_c;
                    if (dec_any_c) begin
                        rd_d     = bus_d[2*DW+SW +: RW];
                        sel_d    = bus_d[2*DW +: SW];
                        w_data_d = bus_d[0 +: DW];
                    end
                    if (dec_lo_c && dec_hi_c) begin
                        w_data_hi_d = bus_d[DW +: DW];
                    end
                end
                if (dec_illegal_c) begin
                    err_d = 1'b1;
                end
            end
            HI2: begin
                hi_en_d  = 1'b1;
                rd_d     = bus_d[2*DW+SW +: RW];
                sel_d    = bus_d[2*DW +: SW];
                w_data_d = bus_d[DW +: DW];
            end
            default: ;
        endcase

        in_ready_d  = ~split_d;
        byp_valid_d = reg_en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            bus_q        <= '0;
            split_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            reg_en_q     <= 1'b0;
            lo_en_q      <= 1'b0;
            hi_en_q      <= 1'b0;
            cp0_en_q     <= 1'b0;
            rd_q         <= '0;
            sel_q        <= '0;
            w_data_q     <= '0;
            w_data_hi_q  <= '0;
            byp_valid_q  <= 1'b0;
            retire_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            split_q      <= split_d;
            in_ready_q   <= in_ready_d;
            reg_en_q     <= reg_en_d;
            lo_en_q      <= lo_en_d;
            hi_en_q      <= hi_en_d;
            cp0_en_q     <= cp0_en_d;
            rd_q         <= rd_d;
            sel_q        <= sel_d;
            w_data_q     <= w_data_d;
            w_data_hi_q  <= w_data_hi_d;
            byp_valid_q  <= byp_valid_d;
            retire_cnt_q <= retire_cnt_d;
            err_q        <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign reg_en      = reg_en_q;
    assign lo_en       = lo_en_q;
    assign hi_en       = hi_en_q;
    assign cp0_en      = cp0_en_q;
    assign rd          = rd_q;
    assign sel         = sel_q;
    assign w_data      = w_data_q;
    assign w_data_hi   = w_data_hi_q;
    assign byp_valid   = byp_valid_q;
    assign retire_cnt  = retire_cnt_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_wb_stage_hs.sv
// Scoreboard bench for wb_stage_hs: split-HILO instance checked by a monitor, plus a non-split twin.
module tb_wb_stage_hs;

    localparam int unsigned BW = 4 + 5 + 3 + 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          flush;
    logic [BW-1:0] in_bus;

    logic          in_ready, reg_en, lo_en, hi_en, cp0_en, byp_valid, err_illegal;
    logic [4:0]    rd;
    logic [2:0]    sel;
    logic [31:0]   w_data, w_data_hi;
    logic [3:0]    retire_cnt;

    logic          ns_in_ready, ns_reg_en, ns_lo_en, ns_hi_en, ns_cp0_en, ns_byp_valid, ns_err;
    logic [4:0]    ns_rd;
    logic [2:0]    ns_sel;
    logic [31:0]   ns_w_data, ns_w_data_hi;
    logic [31:0]   ns_retire_cnt;

    typedef struct packed {
        logic [3:0]  en;   // {reg, lo, hi, cp0}
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [31:0] wdh;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_stage_hs #(.DW(32), .RW(5), .SW(3), .SPLIT_HILO(1), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
        .flush(flush), .reg_en(reg_en), .lo_en(lo_en), .hi_en(hi_en), .cp0_en(cp0_en),
        .rd(rd), .sel(sel), .w_data(w_data), .w_data_hi(w_data_hi), .byp_valid(byp_valid),
        .retire_cnt(retire_cnt), .err_illegal(err_illegal)
    );

    wb_stage_hs #(.DW(32), .RW(5), .SW(3), .SPLIT_HILO(0), .CW(32)) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready), .in_bus(in_bus),
        .flush(flush), .reg_en(ns_reg_en), .lo_en(ns_lo_en), .hi_en(ns_hi_en), .cp0_en(ns_cp0_en),
        .rd(ns_rd), .sel(ns_sel), .w_data(ns_w_data), .w_data_hi(ns_w_data_hi),
        .byp_valid(ns_byp_valid), .retire_cnt(ns_retire_cnt), .err_illegal(ns_err)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (reg_en | lo_en | hi_en | cp0_en)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {reg_en, lo_en, hi_en, cp0_en}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_en", {reg_en, lo_en, hi_en, cp0_en}, e.en);
                chk("wr_rd", rd, e.rd);
                chk("wr_sel", sel, e.sel);
                chk("wr_data", w_data, e.wd);
                chk("wr_data_hi", w_data_hi, e.wdh);
                chk("byp_valid", byp_valid, e.en[3]);
            end
        end else if (rst_n) begin
            chk("idle_ports", {rd, sel, w_data, w_data_hi, byp_valid}, 0);
        end
    end

    task automatic push_exp(input logic en, input logic [2:0] aim, input logic [4:0] r,
                            input logic [2:0] s, input logic [31:0] hi, input logic [31:0] lo);
        if (en) begin
            case (aim)
                3'd0: exp_q.push_back({4'b1000, r, s, lo, 32'h0});
                3'd1: exp_q.push_back({4'b0100, r, s, lo, 32'h0});
                3'd2: exp_q.push_back({4'b0010, r, s, lo, 32'h0});
                3'd3: exp_q.push_back({4'b0001, r, s, lo, 32'h0});
                3'd4: begin
                    exp_q.push_back({4'b0100, r, s, lo, 32'h0});
                    exp_q.push_back({4'b0010, r, s, hi, 32'h0});
                end
                default: ;
            endcase
        end
    endtask

    // Present a beat until the split instance accepts it; returns one cycle after acceptance.
    task automatic send(input logic en, input logic [2:0] aim, input logic [4:0] r,
                        input logic [2:0] s, input logic [31:0] hi, input logic [31:0] lo);
        int budget = 0;
        in_valid = 1'b1;
        flush    = 1'b0;
        in_bus   = {en, aim, r, s, hi, lo};
        while (!in_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        else push_exp(en, aim, r, s, hi, lo);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_bus   = '0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        wait_cyc(2);
        chk("rst_outputs", {reg_en, lo_en, hi_en, cp0_en, rd, sel, w_data, w_data_hi,
                            byp_valid, retire_cnt, err_illegal}, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_cyc(1);
        chk("ready_after_rst", in_ready, 1);

        // Three back-to-back GPR beats
        send(1'b1, 3'd0, 5'd1, 3'd0, 32'h0, 32'h11);
        chk("gpr_latency", {reg_en, rd}, {1'b1, 5'd1});
        send(1'b1, 3'd0, 5'd2, 3'd0, 32'h0, 32'h22);
        send(1'b1, 3'd0, 5'd3, 3'd0, 32'h0, 32'h33);
        idle();
        wait_cyc(3);
        chk("retire_stream", retire_cnt, 4'd3);

        // HILO beat: split instance writes LO then HI; twin writes both at once
        send(1'b1, 3'd4, 5'd0, 3'd0, 32'hAAAA0000, 32'h0000BBBB);
        idle();
        chk("split_ready_low", in_ready, 0);
        chk("ns_hilo_en", {ns_reg_en, ns_lo_en, ns_hi_en, ns_cp0_en}, 4'b0110);
        chk("ns_w_data", ns_w_data, 32'h0000BBBB);
        chk("ns_w_data_hi", ns_w_data_hi, 32'hAAAA0000);
        wait_cyc(1);
        chk("hi2_write", {hi_en, w_data}, {1'b1, 32'hAAAA0000});
        chk("hi2_ready", in_ready, 1);
        chk("ns_after_hilo", {ns_lo_en, ns_hi_en}, 2'b00);
        wait_cyc(1);
        chk("retire_hilo", retire_cnt, 4'd4);

        // Flush offered during HI2: HI write completes, offered beat is dropped
        send(1'b1, 3'd4, 5'd0, 3'd0, 32'hCAFE0000, 32'h0000F00D);
        idle();
        wait_cyc(1);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_bus   = {1'b1, 3'd0, 5'd7, 3'd0, 32'h0, 32'h77};
        wait_cyc(1);
        idle();
        chk("flush_no_write", {reg_en, lo_en, hi_en, cp0_en}, 0);
        chk("flush_ready", in_ready, 1);
        wait_cyc(1);
        chk("retire_flush", retire_cnt, 4'd5);

        // CP0, LO, HI targets and a bubble
        send(1'b1, 3'd3, 5'd12, 3'd2, 32'h0, 32'hC0C0);
        send(1'b1, 3'd1, 5'd0, 3'd0, 32'h0, 32'h10);
        send(1'b1, 3'd2, 5'd0, 3'd0, 32'h0, 32'h20);
        send(1'b0, 3'd0, 5'd9, 3'd1, 32'h0, 32'h99);
        chk("bubble_no_write", {reg_en, lo_en, hi_en, cp0_en}, 0);
        idle();
        wait_cyc(2);
        chk("retire_misc", retire_cnt, 4'd9);

        // Illegal target is retired and sets a sticky flag
        chk("err_before", err_illegal, 0);
        send(1'b1, 3'd6, 5'd4, 3'd1, 32'h0, 32'h66);
        idle();
        chk("illegal_no_write", {reg_en, lo_en, hi_en, cp0_en}, 0);
        chk("err_set", err_illegal, 1);
        send(1'b1, 3'd0, 5'd5, 3'd0, 32'h0, 32'h55);
        idle();
        wait_cyc(2);
        chk("err_sticky", err_illegal, 1);
        chk("retire_illegal", retire_cnt, 4'd11);

        // Reset asserted while a split HILO is in progress: HI half is lost
        send(1'b1, 3'd4, 5'd0, 3'd0, 32'h12340000, 32'h00005678);
        idle();
        @(negedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_outputs", {reg_en, lo_en, hi_en, cp0_en, rd, sel, w_data, w_data_hi,
                               byp_valid, retire_cnt, err_illegal}, 0);
        chk("midrst_ready", in_ready, 0);
        wait_cyc(2);
        chk("midrst_held", {hi_en, in_ready}, 2'b00);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_cyc(1);
        chk("ready_after_midrst", in_ready, 1);

        // Flush in EMPTY blocks acceptance
        in_valid = 1'b1;
        flush    = 1'b1;
        in_bus   = {1'b1, 3'd0, 5'd8, 3'd0, 32'h0, 32'h88};
        wait_cyc(1);
        idle();
        chk("flush_empty", {reg_en, retire_cnt}, 0);

        // 17 beats on a 4-bit retire counter wrap to 1
        for (int i = 0; i < 17; i++) begin
            send(1'b1, 3'd0, 5'(i), 3'd0, 32'h0, 32'(i + 256));
        end
        idle();
        wait_cyc(3);
        chk("retire_wrap", retire_cnt, 4'd1);
        chk("err_cleared", err_illegal, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
